serial_not16_decoder: RTL

SERIAL_NOT16_DECODER -- requirements
Module: serial_not16_decoder

---
 rtl/serial_not16_decoder_pkg.sv | 21 ++
 rtl/serial_not16_decoder_if.sv | 28 ++
 rtl/serial_not16_decoder_not16.sv | 10 +
 rtl/serial_not16_decoder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/serial_not16_decoder_pkg.sv
// Shared widths, FSM encoding and bit-order helper for the serial decoder.
// Imported by the interface, the top and the testbench.
package not16_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Frame position -> word bit index for the selected bit order.
  function automatic logic [CNT_W-1:0] bit_pos(
    input logic [CNT_W-1:0] c,
    input logic             lsb
  );
    return lsb ? c : (CNT_W'(WORD_W - 1) - c);
  endfunction

endpackage

// File: rtl/serial_not16_decoder_if.sv
// Serial-in / word-out bus of the decoder: serial side, word handshake, flags.
// slave = decoder, master = the block feeding bits and consuming words.
interface serial_not16_decoder_if;
  import not16_pkg::*;

  logic              sin;
  logic              sin_valid;
  logic              sin_start;
  logic              inv_en;
  logic              clr_err;
  logic              out_ready;
  logic [WORD_W-1:0] out;
  logic              out_valid;
  logic              busy;
  logic              overrun;
  logic              framing_err;

  modport master (
    output sin, sin_valid, sin_start, inv_en, clr_err, out_ready,
    input  out, out_valid, busy, overrun, framing_err
  );

  modport slave (
    input  sin, sin_valid, sin_start, inv_en, clr_err, out_ready,
    output out, out_valid, busy, overrun, framing_err
  );

endinterface

// File: rtl/serial_not16_decoder_not16.sv
// 16-bit bitwise inverter used for the optional word complement.
// Ports: a_i word in, y_o complemented word out.
module not_16bit_chip (
  input  logic [15:0] a_i,
  output logic [15:0] y_o
);

  assign y_o = ~a_i;

endmodule

// File: rtl/serial_not16_decoder.sv
// Assembles 16-bit words from a serial stream, optionally complements them.
// Ports: clk, reset (async, high), bus (slave modport of the decoder bus).
module serial_not16_decoder
  import not16_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_not16_decoder_if.slave  bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic              inv_q, inv_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;

  logic              done;
  logic              ovr_set;
  logic              ferr_set;
  logic [WORD_W-1:0] word_n;
  logic [WORD_W-1:0] word;

  // sh_d already holds the 16th bit when done is raised.
  not_16bit_chip u_not (
    .a_i (sh_d),
    .y_o (word_n)
  );

  assign word = inv_q ? word_n : sh_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    inv_d    = inv_q;
    done     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sin_valid && bus.sin_start) begin
          sh_d = '0;
          sh_d[bit_pos('0, LSB_FIRST)] = bus.sin;
          inv_d   = bus.inv_en;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sin_valid && bus.sin_start) begin
          sh_d = '0;
          sh_d[bit_pos('0, LSB_FIRST)] = bus.sin;
          inv_d    = bus.inv_en;
          cnt_d    = CNT_W'(1);
          ferr_set = 1'b1;
        end else if (bus.sin_valid) begin
          sh_d[bit_pos(cnt_q, LSB_FIRST)] = bus.sin;
          if (cnt_q == CNT_W'(WORD_W - 1)) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A held, unconsumed word blocks the new one: drop it and flag it.
  always_comb begin
    out_d   = out_q;
    vld_d   = vld_q;
    ovr_set = 1'b0;
    if (done && (!vld_q || bus.out_ready)) begin
      out_d = word;
      vld_d = 1'b1;
    end else if (done) begin
      ovr_set = 1'b1;
    end else if (vld_q && bus.out_ready) begin
      vld_d = 1'b0;
    end
  end

  // Set beats clear when both happen in one cycle.
  assign ovr_d  = ovr_set  | (ovr_q  & ~bus.clr_err);
  assign ferr_d = ferr_set | (ferr_q & ~bus.clr_err);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      inv_q   <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      inv_q   <= inv_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.out_valid   = vld_q;
  assign bus.busy        = (state_q == SHIFT);
  assign bus.overrun     = ovr_q;
  assign bus.framing_err = ferr_q;

endmodule
